// File: rtl/key_cond_pkg.sv
// Shared types and timing constants for the DE2 key front-end.
// Holds the repeat-FSM state enum, 50 MHz defaults and sim-scale values.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

  localparam int SIM_DEBOUNCE_CYCLES = 8;
  localparam int SIM_REPEAT_DELAY    = 20;
  localparam int SIM_REPEAT_RATE     = 5;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, debounce counter, auto-repeat FSM.
// Ports: CLOCK_50, RESET_N, key_raw (0=pressed) -> press, release_pulse, held.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_raw,
  output logic press,
  output logic release_pulse,
  output logic held
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_RATE);
  localparam int RCW  = $clog2(RMAX);

  localparam logic [CW-1:0]  CNT_TC  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DLY_TC  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RATE_TC = RCW'(REPEAT_RATE - 1);

  logic           s1;
  logic           s2;
  logic           pressed_s;
  logic [CW-1:0]  cnt;
  logic           acc;
  logic           acc_press;
  logic           acc_rel;

  rep_state_t     state;
  rep_state_t     state_n;
  logic [RCW-1:0] rc;
  logic [RCW-1:0] rc_n;
  logic           rep_press;

  assign pressed_s = ~s2;
  assign acc       = (pressed_s != held) && (cnt == CNT_TC);
  assign acc_press = acc & pressed_s;
  assign acc_rel   = acc & ~pressed_s;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      cnt           <= '0;
      held          <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= key_raw;
      s2            <= s1;
      press         <= acc_press | rep_press;
      release_pulse <= acc_rel;
      if (pressed_s == held) begin
        cnt <= '0;
      end else if (acc) begin
        held <= pressed_s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state <= IDLE;
      rc    <= '0;
    end else begin
      state <= state_n;
      rc    <= rc_n;
    end
  end

  // A release accepted on a terminal-count cycle suppresses the repeat.
  always_comb begin
    state_n   = state;
    rc_n      = rc;
    rep_press = 1'b0;
    unique case (state)
      IDLE: begin
        if (REPEAT_EN && acc_press) begin
          state_n = DELAY;
          rc_n    = '0;
        end
      end
      DELAY: begin
        if (acc_rel) begin
          state_n = IDLE;
          rc_n    = '0;
        end else if (rc == DLY_TC) begin
          state_n   = REPEAT;
          rc_n      = '0;
          rep_press = 1'b1;
        end else begin
          rc_n = rc + 1'b1;
        end
      end
      REPEAT: begin
        if (acc_rel) begin
          state_n = IDLE;
          rc_n    = '0;
        end else if (rc == RATE_TC) begin
          rc_n      = '0;
          rep_press = 1'b1;
        end else begin
          rc_n = rc + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        rc_n    = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounced press/release/held and auto-repeat for the raw DE2 KEYs.
// Ports: CLOCK_50, RESET_N, KEY (0=pressed) -> press, release_pulse, held.
// release_pulse carries the release events ("release" is a reserved word).
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = NUM_KEYS'(4'b0011)
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] held
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .CLOCK_50      (CLOCK_50),
      .RESET_N       (RESET_N),
      .key_raw       (KEY[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .held          (held[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner at sim-scale timing.
// Event-level model of debounce/repeat plus directed literal checks.
module tb_key_conditioner;
  import key_cond_pkg::*;

  localparam int DC = SIM_DEBOUNCE_CYCLES;
  localparam int RD = SIM_REPEAT_DELAY;
  localparam int RR = SIM_REPEAT_RATE;
  localparam logic [3:0] MASK = 4'b0011;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] held;

  int errors;
  int checks;
  bit chk_en;

  key_conditioner #(
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .REPEAT_MASK     (MASK)
  ) dut (
    .CLOCK_50      (clk),
    .RESET_N       (rst_n),
    .KEY           (key),
    .press         (press),
    .release_pulse (rel),
    .held          (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [3:0] got, logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, got, exp, $time);
    end
  endtask

  // Model: raw KEY reaches the debouncer two edges late; a level is
  // accepted after DC consecutive mismatching edges; repeats fall at
  // RD, RD+RR, RD+2RR ... edges after the accepted press.
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] m_held;
  logic [3:0] m_press;
  logic [3:0] m_rel;
  int         run [4];
  int         tp [4];
  bit         act [4];
  int         cyc;

  initial begin
    d0 = 4'hf; d1 = 4'hf; m_held = '0; m_press = '0; m_rel = '0; cyc = 0;
    for (int k = 0; k < 4; k++) begin
      run[k] = 0; tp[k] = 0; act[k] = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    m_press = '0;
    m_rel   = '0;
    if (!rst_n) begin
      d0 = 4'hf; d1 = 4'hf; m_held = '0;
      for (int k = 0; k < 4; k++) begin
        run[k] = 0; act[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic sv;
        int   d;
        sv = ~d1[k];
        run[k] = (sv != m_held[k]) ? run[k] + 1 : 0;
        d = cyc - tp[k];
        if (run[k] == DC) begin
          m_held[k] = sv;
          run[k] = 0;
          if (sv) begin
            m_press[k] = 1'b1; tp[k] = cyc; act[k] = 1;
          end else begin
            m_rel[k] = 1'b1; act[k] = 0;
          end
        end else if (act[k] && MASK[k]) begin
          if (d == RD || (d > RD && (d - RD) % RR == 0))
            m_press[k] = 1'b1;
        end
      end
      d1 = d0;
      d0 = key;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_press", press, m_press);
      chk("model_release", rel, m_rel);
      chk("model_held", held, m_held);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    chk_en = 0;
    rst_n  = 1'b0;
    key    = 4'hf;
    step(3);
    chk_en = 1;
    chk("reset_press", press, 4'h0);
    chk("reset_held", held, 4'h0);
    rst_n = 1'b1;
    step(4);

    // 1: masked key, single press
    key = 4'b1011;
    step(9);
    chk("s1_held_e8", {3'b0, held[2]}, 4'd0);
    chk("s1_press_e8", {3'b0, press[2]}, 4'd0);
    step(1);
    chk("s1_press_e9", {3'b0, press[2]}, 4'd1);
    chk("s1_held_e9", {3'b0, held[2]}, 4'd1);
    step(1);
    chk("s1_press_e10", {3'b0, press[2]}, 4'd0);
    step(40);
    key = 4'hf;
    step(14);

    // 2: glitchy press rejected, then a clean one accepted
    key = 4'b1011; step(5);
    key = 4'b1111; step(1);
    key = 4'b1011; step(5);
    chk("s2_no_held", {3'b0, held[2]}, 4'd0);
    step(10);
    chk("s2_held", {3'b0, held[2]}, 4'd1);
    key = 4'hf;
    step(14);

    // 3: repeating key
    key = 4'b1110;
    step(10);
    chk("s3_press_e9", {3'b0, press[0]}, 4'd1);
    step(20);
    chk("s3_press_e29", {3'b0, press[0]}, 4'd1);
    step(1);
    chk("s3_press_e30", {3'b0, press[0]}, 4'd0);
    step(4);
    chk("s3_press_e34", {3'b0, press[0]}, 4'd1);
    step(35);
    key = 4'hf;
    step(10);
    chk("s3_release", {3'b0, rel[0]}, 4'd1);
    step(10);

    // 4: simultaneous keys
    key = 4'b0110;
    step(10);
    chk("s4_press_both", press, 4'b1001);
    step(30);
    key = 4'hf;
    step(14);

    // 5: reset while held
    key = 4'b1101;
    step(25);
    rst_n = 1'b0;
    step(1);
    chk("s5_rst_press", press, 4'h0);
    chk("s5_rst_held", held, 4'h0);
    step(2);
    rst_n = 1'b1;
    step(9);
    chk("s5_press_e36", {3'b0, press[1]}, 4'd0);
    step(1);
    chk("s5_press_e37", {3'b0, press[1]}, 4'd1);
    step(40);
    key = 4'hf;
    step(14);

    // 6: release accepted on a repeat terminal count
    key = 4'b1110;
    step(35);
    key = 4'hf;
    step(10);
    chk("s6_release", {3'b0, rel[0]}, 4'd1);
    chk("s6_no_press", {3'b0, press[0]}, 4'd0);
    step(12);

    // random phase
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 13) == 0) key[k] = ~key[k];
      rst_n = ($urandom_range(0, 599) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
